// File: rtl/lsu_pkg.sv
// Shared types for the data memory / load-store unit: access size codes,
// controller states and the funct3 legality rule.
package lsu_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        case (f3)
            MEM_B, MEM_H, MEM_W: return 1'b1;
            MEM_BU, MEM_HU:      return !is_store;
            default:             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational lane steering: merges store data into the addressed lanes,
// extracts and extends load data, and flags misaligned halfword/word accesses.
module byte_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] stored_word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] merged_word,
    output logic [31:0] load_value,
    output logic        misaligned
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        merged_word = stored_word;
        load_value  = '0;
        misaligned  = 1'b0;
        sel_byte    = 8'(stored_word >> {addr_lo, 3'b000});
        sel_half    = 16'(stored_word >> {addr_lo[1], 4'b0000});
        case (mem_funct3_t'(funct3))
            MEM_B: begin
                merged_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
                load_value = {{24{sel_byte[7]}}, sel_byte};
            end
            MEM_BU: load_value = {24'h0, sel_byte};
            MEM_H: begin
                misaligned = addr_lo[0];
                merged_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
                load_value = {{16{sel_half[15]}}, sel_half};
            end
            MEM_HU: begin
                misaligned = addr_lo[0];
                load_value = {16'h0, sel_half};
            end
            MEM_W: begin
                misaligned  = |addr_lo;
                merged_word = wdata;
                load_value  = stored_word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_memory_lsu.sv
// Data memory with load/store unit: valid/ready request and response, fixed
// response latency, and error reporting for illegal, misaligned or out-of-range accesses.
module data_memory_lsu
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [32*DEPTH_WORDS-1:0] initial_values,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [2:0]                req_funct3,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [31:0]               resp_rdata,
    output logic                      resp_error,
    output logic [32*DEPTH_WORDS-1:0] memory_check
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // WAIT lasts LATENCY-1 cycles; the counter runs 0..CNT_LAST inclusive.
    localparam logic [3:0] CNT_LAST = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    logic [31:0]      mem [DEPTH_WORDS];
    lsu_state_t       state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [31:0]      rdata_reg;
    logic             error_reg;

    logic [IDX_W-1:0] idx;
    logic             out_of_range;
    logic             illegal;
    logic             misaligned;
    logic             access_error;
    logic             accept;
    logic [31:0]      merged_word;
    logic [31:0]      load_value;

    assign idx          = req_addr[IDX_W+1:2];
    assign out_of_range = |req_addr[31:IDX_W+2];
    assign illegal      = !funct3_legal(req_write, req_funct3);
    assign access_error = illegal | misaligned | out_of_range;
    assign req_ready    = (state_reg == IDLE) && !reset;
    assign accept       = req_valid && req_ready;
    assign resp_valid   = (state_reg == RESP);
    assign resp_rdata   = rdata_reg;
    assign resp_error   = error_reg;

    byte_lane_align u_align (
        .stored_word (mem[idx]),
        .addr_lo     (req_addr[1:0]),
        .funct3      (req_funct3),
        .wdata       (req_wdata),
        .merged_word (merged_word),
        .load_value  (load_value),
        .misaligned  (misaligned)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    cnt_next   = '0;
                    state_next = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stores commit and load results are captured at the acceptance edge, so the
    // response is independent of anything that happens during the latency window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            error_reg <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= initial_values[32*i +: 32];
            end
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                rdata_reg <= (req_write || access_error) ? 32'h0 : load_value;
                error_reg <= access_error;
                if (req_write && !access_error) begin
                    mem[idx] <= merged_word;
                end
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH_WORDS; gi++) begin : g_words
        assign memory_check[32*gi +: 32] = mem[gi];
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: a LATENCY=1 instance checked against a behavioural
// memory model, plus a LATENCY=4 instance for back-pressure and reset-in-flight.
module tb_data_memory_lsu;

    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset1, reset4;
    logic [32*DEPTH-1:0] init_vals;

    logic               a_req_valid, a_req_write, a_resp_ready;
    logic [2:0]         a_funct3;
    logic [31:0]        a_addr, a_wdata;
    logic               a_req_ready, a_resp_valid, a_resp_error;
    logic [31:0]        a_rdata;
    logic [32*DEPTH-1:0] a_mem;

    logic               b_req_valid, b_req_write, b_resp_ready;
    logic [2:0]         b_funct3;
    logic [31:0]        b_addr, b_wdata;
    logic               b_req_ready, b_resp_valid, b_resp_error;
    logic [31:0]        b_rdata;
    logic [32*DEPTH-1:0] b_mem;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];

    data_memory_lsu #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset1), .initial_values(init_vals),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_funct3(a_funct3), .req_addr(a_addr), .req_wdata(a_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rdata(a_rdata),
        .resp_error(a_resp_error), .memory_check(a_mem)
    );

    data_memory_lsu #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_lat4 (
        .clk(clk), .reset(reset4), .initial_values(init_vals),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_funct3(b_funct3), .req_addr(b_addr), .req_wdata(b_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_rdata),
        .resp_error(b_resp_error), .memory_check(b_mem)
    );

    // Reference: byte-addressed memory with size/extension rules applied arithmetically.
    task automatic model_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int          size, off;
        logic        legal, signed_ld;
        logic [31:0] word, mask, val;
        logic [4:0]  widx;
        off       = int'(addr[1:0]);
        widx      = addr[6:2];
        size      = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal     = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        signed_ld = (f3 <= 3'd1);
        er        = !legal || ((off % size) != 0) || (addr >= 32'(DEPTH * 4));
        rd        = 32'h0;
        if (!er) begin
            word = model_mem[widx];
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
            if (wr) begin
                model_mem[widx] = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            end else begin
                val = (word >> (8 * off)) & mask;
                if (signed_ld && val[8*size-1]) val = val | ~mask;
                rd = val;
            end
        end
    endtask

    function automatic logic [32*DEPTH-1:0] model_packed();
        logic [32*DEPTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[32*i +: 32] = model_mem[i];
        return v;
    endfunction

    // Issues one request on the LATENCY=1 instance and returns the response and its latency.
    task automatic a_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output logic er,
                            output int lat);
        @(negedge clk);
        a_req_valid  = 1'b1;
        a_req_write  = wr;
        a_funct3     = f3;
        a_addr       = addr;
        a_wdata      = wd;
        a_resp_ready = 1'b1;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        lat = 0;
        rd  = 32'hx;
        er  = 1'bx;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (a_resp_valid === 1'b1) break;
        end
        rd = a_rdata;
        er = a_resp_error;
        @(posedge clk);
        #1;
        $display("txn lat1 wr=%0b f3=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0b lat=%0d",
                 wr, f3, addr, wd, rd, er, lat);
    endtask

    task automatic test_reset;
        reset1 = 1'b1;
        reset4 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%0b exp=0", a_req_ready); end
        checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%0b exp=0", a_resp_valid); end
        checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%08h exp=0", a_rdata); end
        checks++; if (a_resp_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%0b exp=0", a_resp_error); end
        checks++; if (a_mem !== init_vals) begin errors++; $display("FAIL reset_memory word0 got=%08h exp=%08h", a_mem[31:0], init_vals[31:0]); end
        checks++; if (b_req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready_lat4 got=%0b exp=0", b_req_ready); end
        reset1 = 1'b0;
        reset4 = 1'b0;
        @(negedge clk);
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%0b exp=1", a_req_ready); end
        checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready_lat4 got=%0b exp=1", b_req_ready); end
        $display("txn reset released");
    endtask

    task automatic test_loads;
        logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adrs [4] = '{32'h4, 32'h5, 32'h6, 32'h6};
        logic [31:0] exps [4] = '{32'hFFFF_FFF3, 32'h0000_00F2, 32'hFFFF_8081, 32'h0000_8081};
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            model_access(1'b0, f3s[i], adrs[i], 32'h0, mrd, mer);
            a_access(1'b0, f3s[i], adrs[i], 32'h0, rd, er, lat);
            checks++; if (rd !== exps[i]) begin errors++; $display("FAIL load%0d_rdata got=%08h exp=%08h", i, rd, exps[i]); end
            checks++; if (er !== 1'b0) begin errors++; $display("FAIL load%0d_error got=%0b exp=0", i, er); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL load%0d_latency got=%0d exp=1", i, lat); end
        end
    endtask

    task automatic test_store_byte;
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat;
        model_access(1'b1, 3'b000, 32'h9, 32'h0000_00AB, mrd, mer);
        a_access(1'b1, 3'b000, 32'h9, 32'h0000_00AB, rd, er, lat);
        checks++; if (a_mem[64 +: 32] !== 32'h1122_AB44) begin errors++; $display("FAIL sb_memory got=%08h exp=1122ab44", a_mem[64 +: 32]); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sb_response got=%08h/%0b exp=0/0", rd, er); end
        a_access(1'b0, 3'b010, 32'h8, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h1122_AB44 || er !== 1'b0) begin errors++; $display("FAIL lw_after_sb got=%08h/%0b exp=1122ab44/0", rd, er); end
    endtask

    task automatic test_errors;
        logic        wrs  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3s  [4] = '{3'b010, 3'b001, 3'b010, 3'b011};
        logic [31:0] adrs [4] = '{32'h6, 32'h3, 32'h80, 32'h4};
        logic [32*DEPTH-1:0] snap;
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            snap = a_mem;
            model_access(wrs[i], f3s[i], adrs[i], 32'hFFFF_FFFF, mrd, mer);
            a_access(wrs[i], f3s[i], adrs[i], 32'hFFFF_FFFF, rd, er, lat);
            checks++; if (er !== 1'b1) begin errors++; $display("FAIL err%0d_flag got=%0b exp=1", i, er); end
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err%0d_rdata got=%08h exp=0", i, rd); end
            checks++; if (a_mem !== snap) begin errors++; $display("FAIL err%0d_memory_changed word0 got=%08h exp=%08h", i, a_mem[31:0], snap[31:0]); end
        end
    endtask

    task automatic test_random;
        logic        wr, er, mer;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rd, mrd;
        int          lat;
        for (int n = 0; n < 300; n++) begin
            wr   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
            wd   = $urandom;
            model_access(wr, f3, addr, wd, mrd, mer);
            a_access(wr, f3, addr, wd, rd, er, lat);
            checks++; if (rd !== mrd || er !== mer) begin errors++; $display("FAIL rand%0d_resp got=%08h/%0b exp=%08h/%0b", n, rd, er, mrd, mer); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL rand%0d_latency got=%0d exp=1", n, lat); end
            checks++; if (a_mem !== model_packed()) begin errors++; $display("FAIL rand%0d_memory addr=%08h", n, addr); end
        end
    endtask

    task automatic test_latency_backpressure;
        logic [31:0] held;
        int          lat;
        @(negedge clk);
        b_req_valid  = 1'b1;
        b_req_write  = 1'b0;
        b_funct3     = 3'b010;
        b_addr       = 32'h4;
        b_wdata      = 32'h0;
        b_resp_ready = 1'b0;
        checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL lat4_ready_before got=%0b exp=1", b_req_ready); end
        @(posedge clk);
        // Keep a store request asserted while busy; it must be ignored.
        #1;
        b_req_write = 1'b1;
        b_addr      = 32'h14;
        b_wdata     = 32'hCAFE_F00D;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (b_resp_valid === 1'b1) break;
        end
        checks++; if (lat !== 4) begin errors++; $display("FAIL lat4_latency got=%0d exp=4", lat); end
        checks++; if (b_rdata !== 32'h8081_F2F3 || b_resp_error !== 1'b0) begin errors++; $display("FAIL lat4_resp got=%08h/%0b exp=8081f2f3/0", b_rdata, b_resp_error); end
        held = b_rdata;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (b_resp_valid !== 1'b1 || b_req_ready !== 1'b0 || b_rdata !== held) begin
                errors++; $display("FAIL lat4_hold%0d valid=%0b ready=%0b rdata=%08h exp=1/0/%08h", c, b_resp_valid, b_req_ready, b_rdata, held);
            end
        end
        b_req_valid  = 1'b0;
        b_resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (b_req_ready !== 1'b1 || b_resp_valid !== 1'b0) begin errors++; $display("FAIL lat4_after_handshake ready=%0b valid=%0b exp=1/0", b_req_ready, b_resp_valid); end
        checks++; if (b_mem[32*5 +: 32] !== init_vals[32*5 +: 32]) begin errors++; $display("FAIL lat4_ignored_store got=%08h exp=%08h", b_mem[32*5 +: 32], init_vals[32*5 +: 32]); end
        $display("txn lat4 LW 0x4 latency=%0d rdata=%08h", lat, held);
    endtask

    task automatic test_reset_in_wait;
        @(negedge clk);
        b_req_valid  = 1'b1;
        b_req_write  = 1'b1;
        b_funct3     = 3'b010;
        b_addr       = 32'hC;
        b_wdata      = 32'hDEAD_BEEF;
        b_resp_ready = 1'b1;
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        @(negedge clk);
        checks++; if (b_mem[32*3 +: 32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wait_store_commit got=%08h exp=deadbeef", b_mem[32*3 +: 32]); end
        reset4 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b0) begin errors++; $display("FAIL wait_reset_outputs valid=%0b ready=%0b exp=0/0", b_resp_valid, b_req_ready); end
        checks++; if (b_mem[32*3 +: 32] !== init_vals[32*3 +: 32]) begin errors++; $display("FAIL wait_reset_reload got=%08h exp=%08h", b_mem[32*3 +: 32], init_vals[32*3 +: 32]); end
        reset4 = 1'b0;
        @(negedge clk);
        checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL wait_post_reset_ready got=%0b exp=1", b_req_ready); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (b_resp_valid !== 1'b0) begin errors++; $display("FAIL wait_dropped_resp%0d got=%0b exp=0", c, b_resp_valid); end
        end
        $display("txn lat4 SW 0xdeadbeef to word 3 interrupted by reset");
    endtask

    initial begin
        a_req_valid = 1'b0; a_req_write = 1'b0; a_resp_ready = 1'b1;
        a_funct3 = 3'b0; a_addr = 32'h0; a_wdata = 32'h0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_resp_ready = 1'b1;
        b_funct3 = 3'b0; b_addr = 32'h0; b_wdata = 32'h0;
        reset1 = 1'b1;
        reset4 = 1'b1;
        for (int i = 0; i < DEPTH; i++) init_vals[32*i +: 32] = $urandom;
        init_vals[32*1 +: 32] = 32'h8081_F2F3;
        init_vals[32*2 +: 32] = 32'h1122_3344;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = init_vals[32*i +: 32];

        test_reset();
        test_loads();
        test_store_byte();
        test_errors();
        test_random();
        test_latency_backpressure();
        test_reset_in_wait();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
